tt_autosym_sweeper: RTL
=======================

Name: tt_autosym_sweeper

Overview:
- Sequential harness stage that sits directly upstream of a combinational single-output netlist (6 inputs → y0) and consumes its output.
- Sweeps every input vector into the netlist and captures the resulting truth table.
- Checks the captured table against a golden table (original vs optimised equivalence).
- Computes the autosymmetry linear space L_f = {α : f(x) = f(x⊕α) for all x}, its size, and the degree k = log2|L_f|.

Parameters:
- N_IN, 6, number of netlist inputs.
- TT_W, 2**N_IN (64), truth-table width. Derived; not overridable.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  one-cycle request. Sampled only in IDLE.
- golden  in  TT_W  expected truth table; bit i = f(i). Registered on start.
- dut_x  out  N_IN  input vector driven to the netlist; bit j drives xj.
- dut_y  in  1  netlist output (y0), combinational response to dut_x.
- busy  out  1  high in SWEEP and SCAN.
- done  out  1  one-cycle pulse when results are valid.
- tt  out  TT_W  captured truth table.
- mismatch_cnt  out  N_IN+1  count of i with dut_y(i) ≠ golden[i].
- equiv  out  1  mismatch_cnt == 0.
- ls_size  out  N_IN+1  |L_f|, including α=0.
- degree  out  clog2(N_IN+1)  log2(ls_size).

Behaviour:
- Reset (asynchronous assert, synchronous release):
  - state = IDLE; dut_x = 0; busy = 0; done = 0.
  - tt = 0; mismatch_cnt = 0; equiv = 0; ls_size = 0; degree = 0; internal counters = 0.
- FSM states: IDLE, SWEEP, SCAN, DONE.
- IDLE, start=1 at edge E:
  - golden_r ← golden; idx ← 0; mismatch_cnt ← 0; ls_size ← 1 (α=0 always in L_f); equiv ← 0.
  - Go to SWEEP.
- SWEEP:
  - dut_x = idx (driven from a register).
  - Each edge: tt[idx] ← dut_y; mismatch_cnt increments if dut_y ≠ golden_r[idx].
  - idx increments. After idx = TT_W−1 is captured, go to SCAN with α ← 1.
  - Exactly TT_W cycles, one vector per cycle.
  - dut_x holds the last vector (TT_W−1) outside SWEEP until the next start.
- SCAN:
  - One α per cycle, α = 1..TT_W−1 (TT_W−1 cycles).
  - Permuted table p[x] = tt[x⊕α], computed combinationally.
  - If p == tt, ls_size increments. α wraps to 0 after TT_W−1, then go to DONE.
- DONE (one cycle):
  - done = 1; equiv ← (mismatch_cnt == 0); degree ← log2(ls_size).
  - ls_size is always a power of two, so degree = index of its single set bit.
  - Go to IDLE.
- Latency: start at edge E → done high during the cycle after edge E + TT_W + TT_W − 1 + 1 (129 cycles for N_IN = 6).
- Results (tt, mismatch_cnt, equiv, ls_size, degree) hold until the next accepted start. During a run they are intermediate and not valid.
- start while busy or in DONE: ignored, no effect.
- golden changing after start: ignored; the registered copy is used.
- rst mid-run: immediate return to reset values. No done pulse. Partial results are discarded.
- Width rules:
  - mismatch_cnt and ls_size max = TT_W (64) and must not wrap; N_IN+1 bits.
  - Counters are unsigned.

Decomposition:
- Package tt_autosym_pkg:
  - N_IN, TT_W, IDX_W = N_IN, CNT_W = N_IN+1, DEG_W.
  - State enum {IDLE, SWEEP, SCAN, DONE}.
  - Function log2_onehot(ls_size) → degree.
- Sub-module tt_xor_permute (purely combinational, parameterised by N_IN):
  - Inputs tt[TT_W], alpha[N_IN]; output p[TT_W] with p[x] = tt[x⊕alpha].
  - Separately testable.

Test Plan:
- DUT model f ≡ 0, golden = 0 → tt = 0, mismatch_cnt = 0, equiv = 1, ls_size = 64, degree = 6; done exactly 129 cycles after start.
- f = x0, golden = 0xAAAA_AAAA_AAAA_AAAA → tt = golden, equiv = 1, ls_size = 32, degree = 5.
- f = x0 & x1 (tt = 0x8888_8888_8888_8888) → ls_size = 16, degree = 4. Also f = x0&x1&x2&x3&x4&x5 (tt = 1<<63) → ls_size = 1, degree = 0.
- f = x0, golden with bits 5 and 40 flipped → mismatch_cnt = 2, equiv = 0. ls_size is still 32 (computed on captured tt, not golden).
- Assert rst at SWEEP idx = 20 → all outputs 0 immediately, no done. Then a fresh start gives correct results for f ≡ 0.
- Pulse start at SWEEP idx = 10 and in the SCAN cycle α = 30 → ignored; single done at cycle 129, results unchanged.

Source files
------------

// File: rtl/tt_autosym_pkg.sv
// Shared constants, FSM state type and the one-hot-to-log2 helper for the
// truth-table sweeper and autosymmetry scanner.
package tt_autosym_pkg;

    localparam int N_IN  = 6;
    localparam int TT_W  = 2 ** N_IN;
    localparam int IDX_W = N_IN;
    localparam int CNT_W = N_IN + 1;
    localparam int DEG_W = $clog2(N_IN + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SWEEP = 2'd1,
        SCAN  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // |L_f| is always a power of two, so the set bit's position is its log2.
    function automatic logic [DEG_W-1:0] log2_onehot(input logic [CNT_W-1:0] v);
        logic [DEG_W-1:0] r;
        r = '0;
        for (int i = 0; i < CNT_W; i++) begin
            if (v[i]) r = DEG_W'(i);
        end
        return r;
    endfunction

endpackage

// File: rtl/tt_xor_permute.sv
// Combinational input-space translation of a truth table: p[x] = tt[x ^ alpha].
module tt_xor_permute #(
    parameter int N_IN = 6
) (
    input  logic [2**N_IN-1:0] tt,
    input  logic [N_IN-1:0]    alpha,
    output logic [2**N_IN-1:0] p
);

    localparam int TT_W = 2 ** N_IN;

    for (genvar x = 0; x < TT_W; x++) begin : g_bit
        localparam logic [N_IN-1:0] XV = N_IN'(x);
        assign p[x] = tt[XV ^ alpha];
    end

endmodule

// File: rtl/tt_autosym_sweeper.sv
// Sweeps all input vectors through an external netlist, captures its truth
// table, compares it with a golden table and measures its autosymmetry space.
module tt_autosym_sweeper
    import tt_autosym_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [TT_W-1:0]  golden,
    output logic [IDX_W-1:0] dut_x,
    input  logic             dut_y,
    output logic             busy,
    output logic             done,
    output logic [TT_W-1:0]  tt,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic             equiv,
    output logic [CNT_W-1:0] ls_size,
    output logic [DEG_W-1:0] degree,
    output logic [1:0]       dbg_state
);

    // Handshake: start is sampled only in IDLE and launches one run; anything
    // else on start is ignored. done pulses for one cycle once all results
    // are valid; results then hold until the next accepted start.

    state_e state_q, state_d;

    logic [TT_W-1:0]  golden_r;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] alpha;
    logic [TT_W-1:0]  perm;

    tt_xor_permute #(.N_IN(N_IN)) u_perm (
        .tt    (tt),
        .alpha (alpha),
        .p     (perm)
    );

    assign dut_x     = idx;
    assign busy      = (state_q == SWEEP) || (state_q == SCAN);
    assign dbg_state = state_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = SWEEP;
            SWEEP:   if (idx == IDX_W'(TT_W - 1)) state_d = SCAN;
            SCAN:    if (alpha == IDX_W'(TT_W - 1)) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            golden_r     <= '0;
            idx          <= '0;
            alpha        <= '0;
            tt           <= '0;
            mismatch_cnt <= '0;
            equiv        <= 1'b0;
            ls_size      <= '0;
            degree       <= '0;
            done         <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        golden_r     <= golden;
                        idx          <= '0;
                        mismatch_cnt <= '0;
                        ls_size      <= CNT_W'(1);
                        equiv        <= 1'b0;
                    end
                end
                SWEEP: begin
                    tt[idx] <= dut_y;
                    if (dut_y != golden_r[idx]) mismatch_cnt <= mismatch_cnt + CNT_W'(1);
                    // idx parks on the last vector so dut_x holds it until the next run.
                    if (idx == IDX_W'(TT_W - 1)) alpha <= IDX_W'(1);
                    else                         idx   <= idx + IDX_W'(1);
                end
                SCAN: begin
                    if (perm == tt) ls_size <= ls_size + CNT_W'(1);
                    alpha <= alpha + IDX_W'(1);
                end
                DONE: begin
                    done   <= 1'b1;
                    equiv  <= (mismatch_cnt == '0);
                    degree <= log2_onehot(ls_size);
                end
                default: ;
            endcase
        end
    end

endmodule
